// File: rtl/size_handler_ctrl.sv
// Load/store size controller: word-aligned memory access with read-modify-write for sub-word stores.
// Optional SIZEH_SIGN_EXT_EN enables sign extension of ld_half/ld_byte when req_unsigned=0.
//
// state | meaning
// IDLE  | ready for a request
// RD    | memory read in flight (MEM_LAT cycles), capture on last cycle
// WR    | single-cycle memory write
// DONE  | completion pulse, err valid
module size_handler_ctrl #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ld_word,
    output logic [31:0] ld_half,
    output logic [31:0] ld_byte,
    output logic [1:0]  ld_sel,
    output logic        done,
    output logic        err
);

    localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0] cnt;
    logic [1:0]    size_q;
    logic [1:0]    lane_q;
    logic          we_q;
    logic          err_q;
    logic [15:0]   wdata_q;
    logic          uns_q;

    logic          accept;
    logic          misaligned;
    logic          rd_last;
    logic [15:0]   half_raw;
    logic [7:0]    byte_raw;
    logic          half_sign;
    logic          byte_sign;
    logic [31:0]   merged;

    assign req_ready = (state == IDLE);
    assign mem_wr    = (state == WR);
    assign done      = (state == DONE);
    assign err       = done && err_q;

    assign accept  = req_valid && req_ready;
    assign rd_last = (state == RD) && (cnt == '0);

    always_comb begin
        misaligned = 1'b0;
        if (req_size == SZ_RSVD)
            misaligned = 1'b1;
        else if (req_size == SZ_WORD)
            misaligned = (req_addr[1:0] != 2'b00);
        else if (req_size == SZ_HALF)
            misaligned = req_addr[0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned)
                        state_nxt = DONE;
                    else if (req_we && (req_size == SZ_WORD))
                        state_nxt = WR;
                    else
                        state_nxt = RD;
                end
            end
            RD: begin
                if (rd_last)
                    state_nxt = we_q ? WR : DONE;
            end
            WR:      state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Lane extraction from the word currently on mem_rdata.
    assign half_raw = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    assign byte_raw = mem_rdata[{lane_q, 3'b000} +: 8];

`ifdef SIZEH_SIGN_EXT_EN
    assign half_sign = ~uns_q & half_raw[15];
    assign byte_sign = ~uns_q & byte_raw[7];
`else
    logic unused_uns;
    assign unused_uns = uns_q;
    assign half_sign  = 1'b0;
    assign byte_sign  = 1'b0;
`endif

    always_comb begin
        merged = mem_rdata;
        if (size_q == SZ_HALF) begin
            if (lane_q[1])
                merged[31:16] = wdata_q;
            else
                merged[15:0] = wdata_q;
        end else begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt       <= '0;
            size_q    <= 2'b00;
            lane_q    <= 2'b00;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            uns_q     <= 1'b0;
            wdata_q   <= 16'h0000;
            mem_addr  <= 32'h0000_0000;
            mem_wdata <= 32'h0000_0000;
            ld_word   <= 32'h0000_0000;
            ld_half   <= 32'h0000_0000;
            ld_byte   <= 32'h0000_0000;
            ld_sel    <= 2'b00;
        end else begin
            if (accept) begin
                mem_addr <= {req_addr[31:2], 2'b00};
                size_q   <= req_size;
                lane_q   <= req_addr[1:0];
                we_q     <= req_we;
                uns_q    <= req_unsigned;
                wdata_q  <= req_wdata[15:0];
                err_q    <= misaligned;
                cnt      <= CNT_LOAD;
                // Word stores skip the read, so their data goes straight out.
                if (req_we && (req_size == SZ_WORD) && !misaligned)
                    mem_wdata <= req_wdata;
            end
            if (state == RD) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (we_q) begin
                    mem_wdata <= merged;
                end else begin
                    ld_word <= mem_rdata;
                    ld_half <= {{16{half_sign}}, half_raw};
                    ld_byte <= {{24{byte_sign}}, byte_raw};
                    case (size_q)
                        SZ_WORD: ld_sel <= 2'd0;
                        SZ_HALF: ld_sel <= 2'd1;
                        default: ld_sel <= 2'd2;
                    endcase
                end
            end
        end
    end

endmodule
